// File: rtl/digit_scanner_pkg.sv
// Shared types and constants for the four-digit multiplexed display scanner.
package digit_scanner_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int         DIGITS = 4;
    localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/digit_scanner.sv
// Time-multiplexes four hex nibbles onto a common-anode display, swapping in new
// values only at frame boundaries and blanking leading zeros.
module digit_scanner
    import digit_scanner_pkg::*;
#(
    parameter int DWELL      = 4,
    parameter bit LEAD_BLANK = 1'b1
) (
    input  logic        clkDiv,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [3:0]  an,
    output logic [3:0]  nibble,
    output logic        frame_done
);

    localparam int              DW_W       = $clog2(DWELL + 1);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    state_t          state;
    logic [DW_W-1:0] dwell;
    logic [1:0]      digit;
    logic [15:0]     active;
    logic [15:0]     shadow;
    logic            pending;

    logic            frame_end;
    logic            accept;
    logic [3:0]      an_next;
    logic [3:0]      nibble_next;
    logic [3:0]      an_p1;
    logic [3:0]      nibble_p1;

    // A digit is a leading zero when it and every digit to its left are zero.
    function automatic logic digit_blank(input logic [15:0] val, input logic [1:0] idx);
        logic [15:0] upper;
        upper = val >> {idx, 2'b00};
        return (idx != 2'd0) && (upper == 16'h0000);
    endfunction

    always_comb begin
        frame_end   = (state == SCAN) && (digit == 2'd3) && (dwell == DWELL_LAST);
        load_ready  = reset || (state == IDLE) || !pending;
        accept      = load_valid && load_ready && !reset;
        nibble_next = active[{digit, 2'b00} +: 4];
        an_next     = AN_OFF;
        if (state == SCAN && !(LEAD_BLANK && digit_blank(active, digit))) begin
            an_next = ~(4'b0001 << digit);
        end
    end

    // Stage p1: registered display drive, one cycle behind the scan position.
    always_ff @(posedge clkDiv) begin
        if (reset) begin
            state     <= IDLE;
            dwell     <= '0;
            digit     <= 2'd0;
            active    <= 16'h0000;
            shadow    <= 16'h0000;
            pending   <= 1'b0;
            an_p1     <= AN_OFF;
            nibble_p1 <= 4'h0;
        end else begin
            an_p1     <= an_next;
            nibble_p1 <= nibble_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        active <= load_data;
                        state  <= SCAN;
                        digit  <= 2'd0;
                        dwell  <= '0;
                    end
                end
                SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        digit <= digit + 2'd1;
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                    // New values only land between frames so no frame mixes two values.
                    if (frame_end) begin
                        if (pending) begin
                            active  <= shadow;
                            pending <= 1'b0;
                        end else if (accept) begin
                            active <= load_data;
                        end
                    end else if (accept) begin
                        shadow  <= load_data;
                        pending <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign an         = reset ? AN_OFF : an_p1;
    assign nibble     = reset ? 4'h0 : nibble_p1;
    assign frame_done = frame_end && !reset;

endmodule

// File: tb/tb_digit_scanner.sv
// Randomized and directed bench for digit_scanner against a frame-level reference model.
module tb_digit_scanner;

    localparam int DW    = 2;
    localparam int FRAME = 4 * DW;

    logic        clkDiv = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0000;
    logic        load_ready, load_ready_nb;
    logic [3:0]  an, an_nb, nibble, nibble_nb;
    logic        frame_done, frame_done_nb;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame position counter plus display registers.
    bit          m_scan = 0;
    int          m_pos = 0;
    logic [15:0] m_active = 0, m_shadow = 0;
    bit          m_pend = 0;
    logic [3:0]  m_an = 4'hF, m_an_nb = 4'hF, m_nib = 0;

    always #5 clkDiv = ~clkDiv;

    digit_scanner #(.DWELL(DW), .LEAD_BLANK(1'b1)) dut (
        .clkDiv(clkDiv), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .an(an), .nibble(nibble), .frame_done(frame_done)
    );

    digit_scanner #(.DWELL(DW), .LEAD_BLANK(1'b0)) dut_nb (
        .clkDiv(clkDiv), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready_nb), .an(an_nb), .nibble(nibble_nb), .frame_done(frame_done_nb)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic r);
        bit         acc, fd, e_ready;
        int         dig;
        logic [3:0] e_an, e_an_nb, e_nib;
        @(negedge clkDiv);
        load_valid = v;
        load_data  = d;
        reset      = r;
        #1;
        fd      = !r && m_scan && (m_pos == FRAME - 1);
        e_ready = r || !m_scan || !m_pend;
        e_an    = r ? 4'hF : m_an;
        e_an_nb = r ? 4'hF : m_an_nb;
        e_nib   = r ? 4'h0 : m_nib;
        check_val("an", an, e_an);
        check_val("an_nb", an_nb, e_an_nb);
        check_val("nibble", nibble, e_nib);
        check_val("nibble_nb", nibble_nb, e_nib);
        check_val("frame_done", frame_done, fd);
        check_val("frame_done_nb", frame_done_nb, fd);
        check_val("load_ready", load_ready, e_ready);
        check_val("load_ready_nb", load_ready_nb, e_ready);
        acc = v && e_ready && !r;
        @(posedge clkDiv);
        if (r) begin
            m_scan = 0; m_pos = 0; m_active = 0; m_shadow = 0; m_pend = 0;
            m_an = 4'hF; m_an_nb = 4'hF; m_nib = 0;
        end else begin
            dig   = m_pos / DW;
            m_nib = 4'((m_active >> (4 * dig)) & 16'hF);
            if (!m_scan) begin
                m_an = 4'hF; m_an_nb = 4'hF;
            end else begin
                m_an_nb = 4'(~(1 << dig));
                m_an    = (dig > 0 && (m_active >> (4 * dig)) == 0) ? 4'hF : m_an_nb;
            end
            if (!m_scan) begin
                if (acc) begin m_active = d; m_scan = 1; m_pos = 0; end
            end else begin
                if (fd) begin
                    if (m_pend) begin m_active = m_shadow; m_pend = 0; end
                    else if (acc) m_active = d;
                end else if (acc) begin
                    m_shadow = d; m_pend = 1;
                end
                m_pos = (m_pos + 1) % FRAME;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic run_to_pos(input int p);
        int guard = 0;
        while (m_pos != p && guard < 50) begin
            step(1'b0, 16'h0000, 1'b0);
            guard++;
        end
        if (guard >= 50) check_val("pos_timeout", guard, 0);
    endtask

    task automatic run_to_free_boundary();
        int guard = 0;
        while (!(m_scan && m_pos == FRAME - 1 && !m_pend) && guard < 50) begin
            step(1'b0, 16'h0000, 1'b0);
            guard++;
        end
        if (guard >= 50) check_val("fd_timeout", guard, 0);
    endtask

    initial begin
        logic [15:0] rd;
        bit          rv, rr;
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1);
        idle(3);

        // Plain display of a full value.
        step(1'b1, 16'h1234, 1'b0);
        idle(20);

        // Mid-frame load, then a second offer held while the first is pending.
        run_to_pos(2);
        step(1'b1, 16'hABCD, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 16'h5555, 1'b0);
        idle(20);

        // Load offered exactly on a boundary with nothing pending.
        run_to_free_boundary();
        step(1'b1, 16'h0042, 1'b0);
        idle(18);
        run_to_free_boundary();
        step(1'b1, 16'h0000, 1'b0);
        idle(18);

        // Reset during digit 2 with a value pending.
        run_to_free_boundary();
        step(1'b1, 16'h1234, 1'b0);
        run_to_pos(1);
        step(1'b1, 16'hABCD, 1'b0);
        run_to_pos(2 * DW);
        step(1'b0, 16'h0000, 1'b1);
        idle(12);
        step(1'b1, 16'h0700, 1'b0);
        idle(10);

        for (int i = 0; i < 1500; i++) begin
            rr = ($urandom_range(0, 199) == 0);
            rv = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       rd = 16'h0000;
                1:       rd = 16'($urandom_range(0, 15)) << (4 * $urandom_range(0, 3));
                default: rd = 16'($urandom);
            endcase
            step(rv, rd, rr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
